// File: rtl/hello_pkg.sv
// Shared definitions for the HELLO rotator driver: char codes, word, FSM states.
package hello_pkg;

  localparam int unsigned CHAR_W = 3;
  localparam int unsigned WORD_W = 15;
  localparam int unsigned SEL_W  = 3;

  localparam logic [CHAR_W-1:0] CH_H     = 3'b000;
  localparam logic [CHAR_W-1:0] CH_E     = 3'b001;
  localparam logic [CHAR_W-1:0] CH_L     = 3'b010;
  localparam logic [CHAR_W-1:0] CH_O     = 3'b011;
  localparam logic [CHAR_W-1:0] CH_BLANK = 3'b100;

  // Leftmost letter sits in the top three bits.
  localparam logic [WORD_W-1:0] HELLO_WORD = {CH_H, CH_E, CH_L, CH_L, CH_O};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Any code with the top bit set renders as blank on the rotator.
  function automatic logic char_is_blank(input logic [CHAR_W-1:0] c);
    return (c & CH_BLANK) != 3'b000;
  endfunction

endpackage

// File: rtl/hello_scroll_ctrl_tick_gen.sv
// Step prescaler: counts 0..TICKS-1 while enabled, flags the terminal count.
module tick_gen #(
  parameter int unsigned TICKS = 4
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  assign wrap = en && (cnt == LAST);

  // Counter register; clear takes precedence over counting.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Timed driver for the HELLO rotator: generates shift select and holds the char word.
module hello_scroll_ctrl
  import hello_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned STEP_HZ  = 2,
  parameter int unsigned TICKS_OV = 0
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Dir,
  input  logic              Load,
  input  logic [WORD_W-1:0] Char_in,
  output logic [SEL_W-1:0]  Sel,
  output logic [WORD_W-1:0] Chars,
  output logic              Tick,
  output logic              Busy
);

  localparam int unsigned TICKS = (TICKS_OV != 0) ? TICKS_OV : (CLK_HZ / STEP_HZ);

  state_t state, state_nx;
  logic   wrap;
  logic   step_c;
  logic   clr_c;
  logic   en;

  assign en = (state == SCROLL);

  tick_gen #(.TICKS(TICKS)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .en       (en),
    .clr      (clr_c),
    .wrap     (wrap)
  );

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, prescaler clear and step decision; Load outranks Stop outranks Start.
  always_comb begin
    state_nx = state;
    step_c   = 1'b0;
    clr_c    = 1'b0;
    if (Load) begin
      clr_c = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Stop) state_nx = SCROLL;
        end
        SCROLL: begin
          if (Stop) begin
            state_nx = HOLD;
            clr_c    = 1'b1;
          end else begin
            step_c = wrap;
          end
        end
        HOLD: begin
          if (Start && !Stop) state_nx = SCROLL;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output registers: select, char word, step pulse, busy flag.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      Sel   <= '0;
      Chars <= HELLO_WORD;
      Tick  <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      Tick <= 1'b0;
      Busy <= (state_nx == SCROLL);
      if (Load) begin
        Chars <= Char_in;
        Sel   <= '0;
      end else if (step_c) begin
        Sel  <= Dir ? Sel - SEL_W'(1) : Sel + SEL_W'(1);
        Tick <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Scoreboard bench for hello_scroll_ctrl with a 4-cycle step period.
module tb_hello_scroll_ctrl;

  logic        clk = 1'b0;
  logic        Reset, Start, Stop, Dir, Load;
  logic [14:0] Char_in;
  logic [2:0]  Sel;
  logic [14:0] Chars;
  logic        Tick, Busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int n_pushed = 0;
  int n_seen = 0;

  typedef struct {
    int         cyc;
    logic [2:0] sel;
  } exp_t;
  exp_t q[$];

  hello_scroll_ctrl #(.CLK_HZ(50_000_000), .STEP_HZ(2), .TICKS_OV(4)) dut (
    .CLOCK_50 (clk),
    .Reset    (Reset),
    .Start    (Start),
    .Stop     (Stop),
    .Dir      (Dir),
    .Load     (Load),
    .Char_in  (Char_in),
    .Sel      (Sel),
    .Chars    (Chars),
    .Tick     (Tick),
    .Busy     (Busy)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after rising edge N, cyc_cnt == N.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  task automatic exp_tick(input int c, input logic [2:0] s);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    q.push_back(e);
    n_pushed++;
  endtask

  // Advance to just after rising edge n.
  task automatic step_to(input int n);
    while (cyc_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every Tick pulse must match the next scheduled step.
  always @(negedge clk) begin
    if (Tick === 1'b1) begin
      exp_t e;
      n_seen++;
      if (q.size() == 0) begin
        chk("unexpected_tick_cycle", 32'(cyc_cnt), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("tick_cycle", 32'(cyc_cnt), 32'(e.cyc));
        chk("tick_sel", 32'(Sel), 32'(e.sel));
      end
    end
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Dir = 1'b0; Load = 1'b0;
    Char_in = 15'h0000;

    // Reset values
    step_to(2);
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_sel", 32'(Sel), 32'd0);
    chk("rst_chars", 32'(Chars), 32'h0293);
    chk("rst_tick", 32'(Tick), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);

    // Idle stays put
    step_to(22);
    @(negedge clk);
    chk("idle_sel", 32'(Sel), 32'd0);
    chk("idle_busy", 32'(Busy), 32'd0);
    chk("idle_chars", 32'(Chars), 32'h0293);

    // Scroll left, entry at edge 23, steps every 4 edges, wrap 7 -> 0
    for (int k = 1; k <= 8; k++) exp_tick(23 + 4 * k, 3'(k));
    Start = 1'b1;
    step_to(23);
    Start = 1'b0;
    @(negedge clk);
    chk("scroll_busy", 32'(Busy), 32'd1);

    // Reverse direction mid-period: 0 -> 7 -> 6 -> 5 -> 4 -> 3
    step_to(56);
    Dir = 1'b1;
    exp_tick(59, 3'd7);
    exp_tick(63, 3'd6);
    exp_tick(67, 3'd5);
    exp_tick(71, 3'd4);
    exp_tick(75, 3'd3);

    // Stop on the wrap edge 79: step suppressed, HOLD
    step_to(78);
    Stop = 1'b1;
    step_to(79);
    @(negedge clk);
    chk("hold_sel", 32'(Sel), 32'd3);
    chk("hold_busy", 32'(Busy), 32'd0);
    chk("hold_tick", 32'(Tick), 32'd0);
    step_to(85);
    Dir = 1'b0;
    step_to(90);
    Stop = 1'b0;
    step_to(98);
    @(negedge clk);
    chk("hold_sel_late", 32'(Sel), 32'd3);
    chk("hold_busy_late", 32'(Busy), 32'd0);

    // Resume: entry at edge 100, first step at 104
    step_to(99);
    Start = 1'b1;
    exp_tick(104, 3'd4);
    step_to(100);
    Start = 1'b0;
    @(negedge clk);
    chk("resume_busy", 32'(Busy), 32'd1);
    chk("resume_sel", 32'(Sel), 32'd3);

    // Load on wrap edge 108: no step, Sel=0, blank word, still scrolling
    step_to(107);
    Load = 1'b1;
    Char_in = 15'h7FFF;
    step_to(108);
    Load = 1'b0;
    Char_in = 15'h0000;
    @(negedge clk);
    chk("load_chars", 32'(Chars), 32'h7FFF);
    chk("load_sel", 32'(Sel), 32'd0);
    chk("load_busy", 32'(Busy), 32'd1);
    chk("load_tick", 32'(Tick), 32'd0);
    for (int k = 1; k <= 5; k++) exp_tick(108 + 4 * k, 3'(k));

    // Reset mid-scroll at Sel=5 (edge 130)
    step_to(129);
    Reset = 1'b1;
    step_to(130);
    Reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_sel", 32'(Sel), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_chars", 32'(Chars), 32'h0293);
    chk("mid_rst_tick", 32'(Tick), 32'd0);

    // Start and Stop together in IDLE: Stop wins, no scrolling
    step_to(131);
    Start = 1'b1;
    Stop = 1'b1;
    step_to(140);
    @(negedge clk);
    chk("ss_busy", 32'(Busy), 32'd0);
    chk("ss_sel", 32'(Sel), 32'd0);
    step_to(141);
    Start = 1'b0;
    Stop = 1'b0;

    step_to(150);
    @(negedge clk);
    chk("missing_ticks", 32'(q.size()), 32'd0);
    chk("tick_count", 32'(n_seen), 32'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
